acfa_log_buffer: RTL

Parametrised control-flow log buffer for the ACFA attestation peripheral space. It replaces the fixed-depth metadata/log block.
- Holds ER_min/ER_max, a hardware-managed log write pointer, control/status and a `LOG_DEPTH`-entry {src,dest} log.
- Supports stop-on-full and wrap (ring) modes, with overflow tracking and a threshold-driven flush request to software.
- Sits on the openMSP430 peripheral bus.
- Is fed by the CFA monitor's append strobe and read by the attestation engine through a dedicated registered port.

---
 rtl/acfa_pkg.sv | 44 ++++
 rtl/acfa_log_ram.sv | 58 +++++
 rtl/acfa_log_buffer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/acfa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : acfa_pkg
//  Purpose  : Shared constants and types for the ACFA control-flow log buffer:
//             register byte offsets, CTRL bit positions, log region layout.
//  Revision : 1.0 - initial release
// ============================================================================
package acfa_pkg;

    // Register byte offsets relative to the peripheral base address
    localparam logic [7:0] REG_ERMIN_OFF  = 8'h00;
    localparam logic [7:0] REG_ERMAX_OFF  = 8'h02;
    localparam logic [7:0] REG_LOGPTR_OFF = 8'h04;
    localparam logic [7:0] REG_CTRL_OFF   = 8'h06;
    localparam logic [7:0] REG_THRESH_OFF = 8'h08;

    // Byte offset where the {src,dest} log entries start
    localparam logic [7:0] LOG_REGION_OFF = 8'h10;

    // Width of one log entry: {src[15:0], dest[15:0]}
    localparam int ENTRY_W = 32;

    // CTRL register bit positions
    localparam int CTRL_WRAP_BIT  = 0;
    localparam int CTRL_EN_BIT    = 1;
    localparam int CTRL_CLR_BIT   = 2;
    localparam int CTRL_FULL_BIT  = 8;
    localparam int CTRL_OVF_BIT   = 9;
    localparam int CTRL_FLUSH_BIT = 10;

    // Log occupancy, derived from the entry count
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_FILLING = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

    // Convert a byte offset into the 14-bit word offset seen on per_addr
    function automatic logic [13:0] word_off(input logic [7:0] byte_off);
        return {7'd0, byte_off[7:1]};
    endfunction

endpackage : acfa_pkg
`default_nettype wire

// File: rtl/acfa_log_ram.sv
`default_nettype none
// ============================================================================
//  Module   : acfa_log_ram
//  Purpose  : DEPTH x 32 log storage. One synchronous write port, one
//             combinational 16-bit half-select read port for the peripheral
//             bus and one registered 32-bit read port for attestation.
//  Revision : 1.0 - initial release
// ============================================================================
module acfa_log_ram
    import acfa_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      bus_addr_i,
    input  logic               bus_half_i,
    output logic [15:0]        bus_rdata_o,
    input  logic [AW-1:0]      att_addr_i,
    output logic [ENTRY_W-1:0] att_rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] bus_entry_w;
    logic [ENTRY_W-1:0] att_rdata_q;

    // Storage array: contents are not reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bus port: half 0 returns src (upper half), half 1 returns dest
    always_comb begin
        bus_entry_w = mem_q[bus_addr_i];
        bus_rdata_o = bus_half_i ? bus_entry_w[15:0] : bus_entry_w[31:16];
    end

    // Attestation port: registered, forwarding a same-cycle write to that slot
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            att_rdata_q <= '0;
        end else if (we_i && (waddr_i == att_addr_i)) begin
            att_rdata_q <= wdata_i;
        end else begin
            att_rdata_q <= mem_q[att_addr_i];
        end
    end

    assign att_rdata_o = att_rdata_q;

endmodule : acfa_log_ram
`default_nettype wire

// File: rtl/acfa_log_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : acfa_log_buffer
//  Purpose  : Parametrised control-flow log buffer on the openMSP430
//             peripheral bus. Holds ER_min/ER_max, control/status, threshold
//             and a LOG_DEPTH-entry {src,dest} log with stop-on-full or ring
//             modes, sticky overflow and a flush request.
//  Revision : 1.0 - initial release
// ============================================================================
module acfa_log_buffer
    import acfa_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0180,
    parameter int          LOG_DEPTH = 256,
    parameter int          LOG_AW    = 8
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic [13:0]       per_addr,
    input  logic [15:0]       per_din,
    input  logic              per_en,
    input  logic [1:0]        per_we,
    output logic [15:0]       per_dout,
    input  logic              cflow_hw_wen,
    input  logic [15:0]       cflow_src,
    input  logic [15:0]       cflow_dest,
    input  logic [LOG_AW-1:0] read_idx,
    output logic [31:0]       read_val,
    output logic [15:0]       ER_min,
    output logic [15:0]       ER_max,
    output logic [LOG_AW:0]   log_count,
    output logic [LOG_AW-1:0] log_head,
    output logic              log_flush_req
);

    // Address decode constants (word addresses)
    localparam logic [13:0]   BASE_WORD   = BASE_ADDR[14:1];
    localparam logic [13:0]   LOG_WORD    = word_off(LOG_REGION_OFF);
    localparam logic [13:0]   END_WORD    = 14'(int'(LOG_REGION_OFF) / 2 + 2 * LOG_DEPTH);
    localparam logic [13:0]   ERMIN_WORD  = word_off(REG_ERMIN_OFF);
    localparam logic [13:0]   ERMAX_WORD  = word_off(REG_ERMAX_OFF);
    localparam logic [13:0]   LOGPTR_WORD = word_off(REG_LOGPTR_OFF);
    localparam logic [13:0]   CTRL_WORD   = word_off(REG_CTRL_OFF);
    localparam logic [13:0]   THRESH_WORD = word_off(REG_THRESH_OFF);
    localparam logic [LOG_AW:0] DEPTH_CNT = (LOG_AW + 1)'(LOG_DEPTH);

    // Software-visible registers
    logic [15:0]       ermin_q;
    logic [15:0]       ermax_q;
    logic [LOG_AW:0]   thresh_q;
    logic              wrap_q;
    logic              en_q;

    // Hardware-managed log state
    logic [LOG_AW-1:0] wptr_q,  wptr_d;
    logic [LOG_AW:0]   count_q, count_d;
    logic [LOG_AW-1:0] head_q,  head_d;
    logic              ovf_q,   ovf_d;

    // Bus decode
    logic [13:0]       off_w;
    logic              sel_w;
    logic              wr_w;
    logic              rd_w;
    logic              log_hit_w;
    logic [LOG_AW:0]   log_off_w;
    logic              clr_w;

    // Status
    occ_state_e        occ_w;
    logic              full_w;
    logic              flush_w;
    logic [15:0]       ctrl_rd_w;

    // Log RAM connections
    logic              ram_we_w;
    logic [LOG_AW-1:0] ram_waddr_w;
    logic [15:0]       ram_bus_w;

    // An address below the base underflows to a large offset and is not selected
    assign off_w     = per_addr - BASE_WORD;
    assign sel_w     = per_en && (off_w < END_WORD);
    assign wr_w      = sel_w && (per_we != 2'b00);
    assign rd_w      = sel_w && (per_we == 2'b00);
    assign log_hit_w = (off_w >= LOG_WORD);
    assign log_off_w = (LOG_AW + 1)'(off_w - LOG_WORD);
    assign clr_w     = wr_w && (off_w == CTRL_WORD) && per_din[CTRL_CLR_BIT];

    // Software register writes (full-word whenever any byte enable is set)
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            ermin_q  <= '0;
            ermax_q  <= '0;
            thresh_q <= '0;
            wrap_q   <= 1'b0;
            en_q     <= 1'b1;
        end else if (wr_w) begin
            if (off_w == ERMIN_WORD) begin
                ermin_q <= per_din;
            end
            if (off_w == ERMAX_WORD) begin
                ermax_q <= per_din;
            end
            if (off_w == CTRL_WORD) begin
                wrap_q <= per_din[CTRL_WRAP_BIT];
                en_q   <= per_din[CTRL_EN_BIT];
            end
            if (off_w == THRESH_WORD) begin
                thresh_q <= per_din[LOG_AW:0];
            end
        end
    end

    // Log pointer/count update: CLR first, then the append using pre-write EN/WRAP
    always_comb begin
        wptr_d   = wptr_q;
        count_d  = count_q;
        head_d   = head_q;
        ovf_d    = ovf_q;
        ram_we_w = 1'b0;

        if (clr_w) begin
            wptr_d  = '0;
            count_d = '0;
            head_d  = '0;
            ovf_d   = 1'b0;
        end

        ram_waddr_w = wptr_d;

        if (cflow_hw_wen && en_q) begin
            if (count_d != DEPTH_CNT) begin
                ram_we_w = 1'b1;
                wptr_d   = wptr_d + 1'b1;
                count_d  = count_d + 1'b1;
            end else begin
                ovf_d = 1'b1;
                if (wrap_q) begin
                    // Ring mode: the oldest entry is overwritten, head follows wptr
                    ram_we_w = 1'b1;
                    wptr_d   = wptr_d + 1'b1;
                    head_d   = wptr_d;
                end
            end
        end
    end

    // Log state register
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            count_q <= count_d;
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    // Occupancy and flush request derived from the current count
    always_comb begin
        if (count_q == '0) begin
            occ_w = OCC_EMPTY;
        end else if (count_q == DEPTH_CNT) begin
            occ_w = OCC_FULL;
        end else begin
            occ_w = OCC_FILLING;
        end
        full_w  = (occ_w == OCC_FULL);
        flush_w = full_w || ((thresh_q != '0) && (count_q >= thresh_q));
    end

    // CTRL readback image; CLR always reads back as 0
    always_comb begin
        ctrl_rd_w                 = 16'h0000;
        ctrl_rd_w[CTRL_WRAP_BIT]  = wrap_q;
        ctrl_rd_w[CTRL_EN_BIT]    = en_q;
        ctrl_rd_w[CTRL_FULL_BIT]  = full_w;
        ctrl_rd_w[CTRL_OVF_BIT]   = ovf_q;
        ctrl_rd_w[CTRL_FLUSH_BIT] = flush_w;
    end

    // Combinational bus read mux; zero when not selected or on reserved words
    always_comb begin
        per_dout = 16'h0000;
        if (rd_w) begin
            if (log_hit_w) begin
                per_dout = ram_bus_w;
            end else begin
                case (off_w)
                    ERMIN_WORD:  per_dout = ermin_q;
                    ERMAX_WORD:  per_dout = ermax_q;
                    LOGPTR_WORD: per_dout = 16'(count_q);
                    CTRL_WORD:   per_dout = ctrl_rd_w;
                    THRESH_WORD: per_dout = 16'(thresh_q);
                    default:     per_dout = 16'h0000;
                endcase
            end
        end
    end

    acfa_log_ram #(
        .DEPTH (LOG_DEPTH),
        .AW    (LOG_AW)
    ) u_log_ram (
        .clk_i       (mclk),
        .rst_i       (puc_rst),
        .we_i        (ram_we_w),
        .waddr_i     (ram_waddr_w),
        .wdata_i     ({cflow_src, cflow_dest}),
        .bus_addr_i  (log_off_w[LOG_AW:1]),
        .bus_half_i  (log_off_w[0]),
        .bus_rdata_o (ram_bus_w),
        .att_addr_i  (read_idx),
        .att_rdata_o (read_val)
    );

    assign ER_min        = ermin_q;
    assign ER_max        = ermax_q;
    assign log_count     = count_q;
    assign log_head      = head_q;
    assign log_flush_req = flush_w;

endmodule : acfa_log_buffer
`default_nettype wire
